prco_fetch: RTL and testbench

PRCO_FETCH -- requirements
Module: prco_fetch

---
 rtl/prco_fetch.sv | 107 ++++++++++
 tb/tb_prco_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_fetch.sv
// Instruction fetch unit: strobes memory at the PC, waits for the read-data-valid
// pulse, and hands the latched instruction to the decoder. Retries on timeout.
module prco_fetch #(
    parameter logic [15:0] P_RESET_PC = 16'h0000,
    parameter int          P_TIMEOUT  = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic        i_jmp,
    input  logic [15:0] i_jmp_addr,
    input  logic        i_halt,
    input  logic        i_mem_valid,
    input  logic [15:0] i_mem_douta,
    output logic        q_ce_fetch,
    output logic [15:0] q_mem_addr,
    output logic [15:0] q_pc,
    output logic [15:0] q_instr,
    output logic        q_ce_dec,
    output logic        q_halted,
    output logic        q_err
);

    typedef enum logic [2:0] {
        S_RESET,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    localparam int             CW       = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(P_TIMEOUT - 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [15:0]    pc_next;
    logic [15:0]    instr_next;
    logic           err_next;
    logic           dec_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pc_next    = q_pc;
        instr_next = q_instr;
        err_next   = q_err;
        dec_next   = 1'b0;
        case (state_reg)
            S_RESET: state_next = S_REQ;
            S_REQ: begin
                state_next = S_WAIT;
                cnt_next   = '0;
            end
            S_WAIT: begin
                // A response landing on the final WAIT cycle still wins over the timeout.
                if (i_mem_valid) begin
                    instr_next = i_mem_douta;
                    dec_next   = 1'b1;
                    state_next = S_HOLD;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_REQ;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_HOLD: begin
                if (i_ce) begin
                    if (i_halt) begin
                        state_next = S_HALT;
                    end else begin
                        pc_next    = i_jmp ? i_jmp_addr : q_pc + 16'd1;
                        state_next = S_REQ;
                    end
                end
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg  <= S_RESET;
            cnt_reg    <= '0;
            q_pc       <= P_RESET_PC;
            q_mem_addr <= P_RESET_PC;
            q_instr    <= 16'h0000;
            q_ce_fetch <= 1'b0;
            q_ce_dec   <= 1'b0;
            q_halted   <= 1'b0;
            q_err      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            q_pc       <= pc_next;
            q_mem_addr <= pc_next;
            q_instr    <= instr_next;
            q_ce_fetch <= (state_next == S_REQ);
            q_ce_dec   <= dec_next;
            q_halted   <= (state_next == S_HALT);
            q_err      <= err_next;
        end
    end

endmodule

// File: tb/tb_prco_fetch.sv
// Randomized bench for prco_fetch: a transaction-level model tracks PC, last
// instruction and error flag while a bench-side memory answers each fetch.
module tb_prco_fetch;

    localparam int P_TIMEOUT = 15;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ce = 1'b0;
    logic        i_jmp = 1'b0;
    logic [15:0] i_jmp_addr = 16'h0000;
    logic        i_halt = 1'b0;
    logic        i_mem_valid = 1'b0;
    logic [15:0] i_mem_douta = 16'h0000;
    logic        q_ce_fetch;
    logic [15:0] q_mem_addr;
    logic [15:0] q_pc;
    logic [15:0] q_instr;
    logic        q_ce_dec;
    logic        q_halted;
    logic        q_err;

    prco_fetch #(
        .P_RESET_PC(16'h0000),
        .P_TIMEOUT (P_TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_jmp      (i_jmp),
        .i_jmp_addr (i_jmp_addr),
        .i_halt     (i_halt),
        .i_mem_valid(i_mem_valid),
        .i_mem_douta(i_mem_douta),
        .q_ce_fetch (q_ce_fetch),
        .q_mem_addr (q_mem_addr),
        .q_pc       (q_pc),
        .q_instr    (q_instr),
        .q_ce_dec   (q_ce_dec),
        .q_halted   (q_halted),
        .q_err      (q_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_pc    = 16'h0000;
    logic [15:0] exp_instr = 16'h0000;
    logic        exp_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_ce = 1'b0;
        i_jmp = 1'b0;
        i_halt = 1'b0;
        i_mem_valid = 1'b0;
    endtask

    // delay = WAIT cycle (1..P_TIMEOUT) in which memory answers; 0 withholds the answer.
    task automatic fetch_txn(input logic [15:0] addr, input logic [15:0] word, input int delay);
        int n = 0;
        int waits;
        while (q_ce_fetch !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("fetch_strobe", {31'd0, q_ce_fetch}, 32'd1);
        chk("fetch_addr", {16'd0, q_mem_addr}, {16'd0, addr});
        chk("fetch_pc", {16'd0, q_pc}, {16'd0, addr});
        // Responses and requests arriving before WAIT must be ignored.
        i_mem_valid = 1'($urandom);
        i_mem_douta = 16'($urandom);
        i_ce = 1'($urandom);
        i_jmp = 1'($urandom);
        i_halt = 1'($urandom);
        i_jmp_addr = 16'($urandom);
        waits = (delay == 0) ? P_TIMEOUT : delay;
        for (int k = 1; k <= waits; k++) begin
            step();
            chk("wait_quiet", {30'd0, q_ce_fetch, q_ce_dec}, 32'd0);
            i_mem_valid = (k == delay);
            i_mem_douta = (k == delay) ? word : 16'($urandom);
            i_ce = 1'($urandom);
            i_jmp = 1'($urandom);
            i_halt = 1'($urandom);
            i_jmp_addr = 16'($urandom);
        end
        step();
        clear_inputs();
        if (delay != 0) begin
            exp_instr = word;
            chk("dec_strobe", {31'd0, q_ce_dec}, 32'd1);
            chk("dec_instr", {16'd0, q_instr}, {16'd0, word});
            chk("dec_no_fetch", {31'd0, q_ce_fetch}, 32'd0);
        end else begin
            exp_err = 1'b1;
            chk("refetch_strobe", {31'd0, q_ce_fetch}, 32'd1);
            chk("refetch_addr", {16'd0, q_mem_addr}, {16'd0, addr});
            chk("refetch_no_dec", {31'd0, q_ce_dec}, 32'd0);
        end
        chk("err_flag", {31'd0, q_err}, {31'd0, exp_err});
        $display("txn fetch addr=%h delay=%0d word=%h err=%0b", addr, delay, word, q_err);
    endtask

    // Idle in HOLD with stray memory pulses, then request the next instruction.
    task automatic hold_advance(input int idle, input logic jmp, input logic [15:0] jaddr);
        for (int k = 0; k < idle; k++) begin
            i_mem_valid = 1'($urandom);
            i_mem_douta = 16'($urandom);
            i_jmp = 1'($urandom);
            i_halt = 1'($urandom);
            i_ce = 1'b0;
            step();
            chk("hold_instr", {16'd0, q_instr}, {16'd0, exp_instr});
            chk("hold_quiet", {30'd0, q_ce_fetch, q_ce_dec}, 32'd0);
        end
        i_ce = 1'b1;
        i_jmp = jmp;
        i_jmp_addr = jaddr;
        i_halt = 1'b0;
        i_mem_valid = 1'($urandom);
        i_mem_douta = 16'($urandom);
        step();
        clear_inputs();
        exp_pc = jmp ? jaddr : exp_pc + 16'd1;
        chk("advance_instr", {16'd0, q_instr}, {16'd0, exp_instr});
        $display("txn advance jmp=%0b next_pc=%h", jmp, exp_pc);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, {16'd0, q_pc}, 32'd0);
        chk({tag, "_addr"}, {16'd0, q_mem_addr}, 32'd0);
        chk({tag, "_instr"}, {16'd0, q_instr}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, q_ce_fetch, q_ce_dec, q_halted}, 32'd0);
        chk({tag, "_err"}, {31'd0, q_err}, 32'd0);
    endtask

    initial begin
        int d;
        int bad;
        logic [15:0] w;

        #3;
        check_reset_values("por");
        step();
        step();
        i_reset = 1'b0;

        // Boot fetch at the reset PC, memory answers one cycle after the strobe.
        fetch_txn(16'h0000, 16'h4fff, 1);

        for (int s = 0; s < 3; s++) begin
            hold_advance($urandom_range(0, 3), 1'b0, 16'h0000);
            fetch_txn(exp_pc, 16'($urandom), $urandom_range(1, 4));
        end

        hold_advance(0, 1'b1, 16'h000d);
        fetch_txn(exp_pc, 16'($urandom), 2);

        hold_advance(1, 1'b1, 16'hffff);
        fetch_txn(exp_pc, 16'($urandom), 1);
        hold_advance(2, 1'b0, 16'h0000);
        fetch_txn(exp_pc, 16'($urandom), 3);

        // Answer on the last permitted WAIT cycle: accepted, no error.
        hold_advance(0, 1'b0, 16'h0000);
        fetch_txn(exp_pc, 16'($urandom), P_TIMEOUT);

        // Withheld answer: timeout, refetch of the same address, then normal completion.
        hold_advance(1, 1'b0, 16'h0000);
        w = 16'($urandom);
        fetch_txn(exp_pc, w, 0);
        fetch_txn(exp_pc, w, 4);

        for (int r = 0; r < 20; r++) begin
            hold_advance($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 16'($urandom));
            w = 16'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, P_TIMEOUT);
            fetch_txn(exp_pc, w, d);
            if (d == 0) fetch_txn(exp_pc, w, $urandom_range(1, P_TIMEOUT));
        end

        // Halt outranks jump; nothing fetched afterwards.
        i_ce = 1'b1;
        i_halt = 1'b1;
        i_jmp = 1'b1;
        i_jmp_addr = 16'h1234;
        step();
        clear_inputs();
        chk("halt_flag", {31'd0, q_halted}, 32'd1);
        chk("halt_pc", {16'd0, q_pc}, {16'd0, exp_pc});
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            i_ce = 1'($urandom);
            i_mem_valid = 1'($urandom);
            i_mem_douta = 16'($urandom);
            step();
            if (q_ce_fetch || q_ce_dec) bad++;
        end
        clear_inputs();
        chk("halt_no_strobes", bad, 0);
        chk("halt_hold_instr", {16'd0, q_instr}, {16'd0, exp_instr});
        chk("halt_sticky", {31'd0, q_halted}, 32'd1);
        $display("txn halt pc=%h", q_pc);

        // Asynchronous reset out of HALT.
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_values("halt_rst");
        step();
        i_reset = 1'b0;
        exp_pc = 16'h0000;
        exp_instr = 16'h0000;
        exp_err = 1'b0;
        step();
        chk("reboot_strobe", {31'd0, q_ce_fetch}, 32'd1);
        step();

        // Reset landing mid-WAIT, then a stale response right after release.
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_values("wait_rst");
        step();
        i_reset = 1'b0;
        i_mem_valid = 1'b1;
        i_mem_douta = 16'hdead;
        step();
        clear_inputs();
        chk("stale_instr", {16'd0, q_instr}, 32'd0);
        chk("stale_no_dec", {31'd0, q_ce_dec}, 32'd0);
        $display("txn reset mid-wait done");
        fetch_txn(16'h0000, 16'h2a5c, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
